// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared state encodings and lane constants for the memory sequencer
package mem_seq_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_LO   = 2'd1,
    MS_HI   = 2'd2,
    MS_DONE = 2'd3
  } ms_state_e;

  localparam logic [1:0]  SEL_LO    = 2'b01;
  localparam logic [1:0]  SEL_HI    = 2'b10;
  localparam logic [1:0]  SEL_W     = 2'b11;
  localparam logic [15:0] RDATA_ERR = 16'hFFFF;

  function automatic logic [15:0] swap_bytes(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - byte-lane steering for bus writes and memout assembly for bus reads
// Purely combinational; the phase inputs say whether the cycle is the first (LO) or second (HI) half.
module mem_lane
  import mem_seq_pkg::*;
(
  input  logic        wr_hi_i,
  input  logic        wr_addr0_i,
  input  logic        wr_byte_i,
  input  logic [15:0] wr_data_i,
  output logic [1:0]  wr_sel_o,
  output logic [15:0] wr_dat_o,
  input  logic        rd_hi_i,
  input  logic        rd_addr0_i,
  input  logic        rd_byte_i,
  input  logic [15:0] rd_dat_i,
  input  logic [7:0]  rd_lo_byte_i,
  output logic [15:0] rd_data_o
);

  always_comb begin
    wr_sel_o = SEL_W;
    wr_dat_o = wr_data_i;
    if (wr_byte_i) begin
      wr_sel_o = wr_addr0_i ? SEL_HI : SEL_LO;
      wr_dat_o = {wr_data_i[7:0], wr_data_i[7:0]};
    end else if (wr_addr0_i) begin
      // Odd word: low byte rides the odd lane first, high byte the even lane of the next word.
      wr_sel_o = wr_hi_i ? SEL_LO : SEL_HI;
      wr_dat_o = swap_bytes(wr_data_i);
    end
  end

  always_comb begin
    rd_data_o = rd_dat_i;
    if (rd_byte_i) begin
      rd_data_o = {8'h00, (rd_addr0_i ? rd_dat_i[15:8] : rd_dat_i[7:0])};
    end else if (rd_addr0_i) begin
      rd_data_o = rd_hi_i ? {rd_dat_i[7:0], rd_lo_byte_i} : {8'h00, rd_dat_i[15:8]};
    end
  end

endmodule

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - sequences datapath memory requests into one or two handshaked 16-bit bus cycles
// Holds the micro-sequencer stalled until the access completes or times out.
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned TO_W      = 8
) (
  input  logic        clk,
  input  logic        boot,
  input  logic        cpu_req,
  input  logic        cpu_we_n,
  input  logic        cpu_byte,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic [18:0] mem_adr,
  output logic [15:0] mem_dat_o,
  input  logic [15:0] mem_dat_i,
  output logic [1:0]  mem_sel,
  output logic        mem_we,
  output logic        mem_stb,
  input  logic        mem_ack
);

  ms_state_e         state_q, state_d;
  logic [19:0]       addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic [7:0]        lo_q, lo_d;
  logic [18:0]       adr_q, adr_d;
  logic [15:0]       dat_q, dat_d;
  logic [1:0]        sel_q, sel_d;
  logic              mem_we_q, mem_we_d;
  logic              stb_q, stb_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic              launch;
  logic              odd_word;
  logic [18:0]       hi_adr;
  logic [TO_W:0]     cnt_inc;
  logic              to_hit;
  logic [1:0]        lane_sel;
  logic [15:0]       lane_dat;
  logic [15:0]       lane_rdata;

  assign launch   = (state_q == MS_IDLE);
  assign odd_word = !byte_q && addr_q[0];
  // (addr+1)[19:1] without carrying an unused bit 0; wraps at the top of the 1 MB space.
  assign hi_adr   = addr_q[19:1] + 19'(addr_q[0]);
  assign cnt_inc  = {1'b0, cnt_q} + (TO_W+1)'(1);
  assign to_hit   = (TO_CYCLES != 0) && (cnt_inc == (TO_W+1)'(TO_CYCLES));

  mem_lane u_lane (
    .wr_hi_i      (state_q == MS_LO),
    .wr_addr0_i   (launch ? cpu_addr[0] : addr_q[0]),
    .wr_byte_i    (launch ? cpu_byte    : byte_q),
    .wr_data_i    (launch ? cpu_wdata   : wdata_q),
    .wr_sel_o     (lane_sel),
    .wr_dat_o     (lane_dat),
    .rd_hi_i      (state_q == MS_HI),
    .rd_addr0_i   (addr_q[0]),
    .rd_byte_i    (byte_q),
    .rd_dat_i     (mem_dat_i),
    .rd_lo_byte_i (lo_q),
    .rd_data_o    (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    byte_d   = byte_q;
    lo_d     = lo_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    mem_we_d = mem_we_q;
    stb_d    = stb_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      MS_IDLE: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          we_d     = !cpu_we_n;
          byte_d   = cpu_byte;
          adr_d    = cpu_addr[19:1];
          sel_d    = lane_sel;
          dat_d    = lane_dat;
          mem_we_d = !cpu_we_n;
          stb_d    = 1'b1;
          cnt_d    = '0;
          state_d  = MS_LO;
        end
      end
      MS_LO, MS_HI: begin
        if (mem_ack) begin
          if (state_q == MS_LO && odd_word) begin
            if (!we_q) lo_d = lane_rdata[7:0];
            adr_d   = hi_adr;
            sel_d   = lane_sel;
            dat_d   = lane_dat;
            cnt_d   = '0;
            state_d = MS_HI;
          end else begin
            if (!we_q) rdata_d = lane_rdata;
            stb_d    = 1'b0;
            mem_we_d = 1'b0;
            state_d  = MS_DONE;
          end
        end else if (to_hit) begin
          // Abandon the access, including any second half still pending.
          stb_d    = 1'b0;
          mem_we_d = 1'b0;
          err_d    = 1'b1;
          rdata_d  = RDATA_ERR;
          cnt_d    = cnt_inc[TO_W-1:0];
          state_d  = MS_DONE;
        end else begin
          cnt_d = cnt_inc[TO_W-1:0];
        end
      end
      MS_DONE: begin
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (boot) begin
      state_q  <= MS_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      lo_q     <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      mem_we_q <= 1'b0;
      stb_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      lo_q     <= lo_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      sel_q    <= sel_d;
      mem_we_q <= mem_we_d;
      stb_q    <= stb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_stall = !boot && ((launch && cpu_req) || state_q == MS_LO || state_q == MS_HI);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign mem_adr   = adr_q;
  assign mem_dat_o = dat_q;
  assign mem_sel   = sel_q;
  assign mem_we    = mem_we_q;
  assign mem_stb   = stb_q;

endmodule
